// File: rtl/bcd_conv_sched_pkg.sv
// Shared definitions for the time-multiplexed binary-to-BCD converter.
// Provides the FSM state type and the per-digit add-3 helper.
package bcd_conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_bin2bcd_core.sv
// Iterative shift-add-3 converter: one bit per clock, BIN_W clocks per operand.
// Owns the {bcd,bin} shift register and the per-digit adjust units.
module bin2bcd_core
  import bcd_conv_sched_pkg::*;
#(
  parameter int unsigned BIN_W      = 24,
  parameter int unsigned BCD_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    done,
  output logic [BCD_DIGITS*4-1:0] bcd_out
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]        bin_q;
  logic [BCD_DIGITS*4-1:0] bcd_q;
  logic [BCD_DIGITS*4-1:0] bcd_adj;
  logic [CNT_W-1:0]        cnt_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      bcd_adj[d*4 +: 4] = add3(bcd_q[d*4 +: 4]);
    end
  end

  // Adjust happens before each shift, so the final shift leaves digits unadjusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt_q <= CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_q <= {bcd_adj[BCD_DIGITS*4-2:0], bin_q[BIN_W-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // High during the cycle whose closing edge performs the last shift.
  assign done    = (cnt_q == CNT_W'(1));
  assign bcd_out = bcd_q;

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter among NUM_REQ requesters.
// Owns the arbiter, the rotating priority pointer, the FSM and the response tag.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BIN_W      = 24,
  parameter int unsigned BCD_DIGITS = 8,
  parameter int unsigned ID_W       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*BIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [BCD_DIGITS*4-1:0]  rsp_bcd,
  output logic                     busy
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            accept;
  logic            core_done;
  logic [BIN_W-1:0] operand;

  // Search starts one past the last winner, so the last-served requester ranks lowest.
  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign accept    = (state_q == IDLE) && found;
  assign operand   = req_data[32'(winner)*BIN_W +: BIN_W];
  assign req_ready = (accept && rst_n) ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = CONV;
      CONV:    if (core_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      rsp_id  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q  <= winner;
        rsp_id <= winner;
      end
    end
  end

  bin2bcd_core #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .bin_in  (operand),
    .done    (core_done),
    .bcd_out (rsp_bcd)
  );

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: a cycle-level behavioural model predicts grants,
// busy and rsp_valid; expected results are queued at accept and checked by a monitor.
module tb_bcd_conv_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned BW = 24;
  localparam int unsigned BD = 8;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*BW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [BD*4-1:0] rsp_bcd;
  logic            busy;

  always #5 clk = ~clk;

  bcd_conv_sched #(
    .NUM_REQ    (NR),
    .BIN_W      (BW),
    .BCD_DIGITS (BD),
    .ID_W       (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_bcd   (rsp_bcd),
    .busy      (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int unsigned     id;
    logic [BD*4-1:0] bcd;
  } exp_t;
  exp_t sbq[$];

  // Model state: phase 0 idle, 1 converting (m_cnt edges left), 2 responding.
  int unsigned   m_phase  = 0;
  int unsigned   m_cnt    = 0;
  int unsigned   m_ptr    = NR - 1;
  logic [NR-1:0] acc_mask = '0;
  bit            rnd_rr   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BD*4-1:0] to_bcd(input int unsigned v);
    logic [BD*4-1:0] r;
    int unsigned     x;
    r = '0;
    x = v;
    for (int d = 0; d < int'(BD); d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin : model
    logic [NR-1:0] er;
    int unsigned   w;
    int unsigned   i;
    bit            hit;
    if (!rst_n) begin
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_rsp_id", 64'(rsp_id), 64'(0));
      chk("reset_rsp_bcd", 64'(rsp_bcd), 64'(0));
      m_phase  = 0;
      m_cnt    = 0;
      m_ptr    = NR - 1;
      acc_mask = '0;
      sbq.delete();
    end else begin
      er  = '0;
      hit = 1'b0;
      w   = 0;
      if (m_phase == 0) begin
        for (int k = 1; k <= int'(NR); k++) begin
          i = (m_ptr + k) % NR;
          if (!hit && req_valid[i]) begin
            hit   = 1'b1;
            w     = i;
            er[i] = 1'b1;
          end
        end
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      acc_mask = er;
      case (m_phase)
        0: if (hit) begin
          sbq.push_back('{w, to_bcd(int'(req_data[w*BW +: BW]))});
          m_ptr   = w;
          m_phase = 1;
          m_cnt   = BW;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    if (rst_n && rsp_valid) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: got id %0d bcd %0h expected no response at %0t",
                 rsp_id, rsp_bcd, $time);
      end else begin
        chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
        chk("rsp_bcd", 64'(rsp_bcd), 64'(sbq[0].bcd));
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  logic [NR-1:0] last_acc = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    last_acc  = acc_mask;
    req_valid = req_valid & ~acc_mask;
    if (rnd_rr) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input int unsigned id, input logic [BW-1:0] val);
    req_data[id*BW +: BW] = val;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_acc(input int unsigned id, input int unsigned budget);
    int unsigned n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc[id] && n < budget);
    if (!last_acc[id]) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got no grant for req%0d expected one within %0d cycles", id, budget);
    end
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((req_valid != '0 || m_phase != 0 || sbq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got pending work after %0d cycles expected drained", budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset with random activity on every input.
    for (int n = 0; n < 4; n++) begin
      req_valid = NR'($urandom);
      req_data  = {$urandom, $urandom, $urandom};
      rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    tick();

    // Single requests with boundary operands.
    issue(0, 24'hFFFFFF); wait_drain(100);
    issue(0, 24'd0);      wait_drain(100);
    issue(0, 24'd999999); wait_drain(100);

    // Arbitration from a fresh pointer: all four, then only 1 and 3.
    do_reset();
    for (int i = 0; i < int'(NR); i++) issue(i, BW'($urandom));
    wait_drain(300);
    issue(1, BW'($urandom));
    issue(3, BW'($urandom));
    wait_drain(200);

    // Backpressure: hold the result for 10 cycles with another request waiting.
    rsp_ready = 1'b0;
    issue(3, BW'($urandom));
    wait_acc(3, 20);
    issue(1, BW'($urandom));
    for (int n = 0; n < 40 && m_phase != 2; n++) tick();
    repeat (10) tick();
    rsp_ready = 1'b1;
    wait_drain(200);

    // Abort in the middle of req2's conversion.
    issue(2, BW'($urandom));
    wait_acc(2, 20);
    repeat (12) tick();
    rst_n = 1'b0;
    issue(0, BW'($urandom));
    issue(2, BW'($urandom));
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_rsp_bcd", 64'(rsp_bcd), 64'(0));
    chk("abort_req_ready", 64'(req_ready), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    wait_drain(200);

    // Operand changes after accept must not disturb the result.
    issue(1, 24'd123456);
    wait_acc(1, 20);
    tick();
    req_data[1*BW +: BW] = BW'($urandom);
    wait_drain(100);

    // Random traffic with random response backpressure.
    rnd_rr = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < int'(NR); i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) issue(i, BW'($urandom));
        else if (req_valid[i] && $urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
      end
      repeat ($urandom_range(1, 30)) tick();
    end
    rnd_rr    = 1'b0;
    rsp_ready = 1'b1;
    wait_drain(2000);
    tick();

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
